// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin arbiter/sequencer sharing one serial
// binary-to-BCD converter (20-bit in, 24-bit out) among NREQ requesters.
// Optional watchdog: define BCD_ARB_TIMEOUT_EN to abort a conversion that
// has not completed within TIMEOUT_CYC cycles (reported via rsp_err_o).
module bcd_conv_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic [NREQ*20-1:0] req_bin_i,
  output logic [NREQ-1:0]    rsp_valid_o,
  output logic [23:0]        rsp_bcd_o,
  output logic               rsp_err_o,
  output logic               conv_start_o,
  output logic [19:0]        conv_bin_o,
  input  logic               conv_busy_i,
  input  logic [23:0]        conv_bcd_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, RUN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]   grant_idx;
  logic            grant_vld;
  logic            grant_fire;
  logic            conv_done;
  logic            to_hit;
  logic [19:0]     bin_q, bin_d, bin_sel;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [23:0]     rsp_bcd_q, rsp_bcd_d;
  logic            rsp_err_q, rsp_err_d;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("bcd_conv_arbiter: NREQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  // Round-robin search starting just after the last winner, plus operand mux
  always_comb begin
    int cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    bin_sel   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_vld && req_valid_i[PW'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(cand);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == PW'(k)) bin_sel = req_bin_i[k*20 +: 20];
    end
  end

  // A grant made while rst is high would be thrown away by the reset edge,
  // so it is suppressed rather than shown to a requester.
  assign grant_fire = (state_q == IDLE) && !rst && !conv_busy_i && grant_vld;
  assign conv_done  = (state_q == RUN) && !conv_busy_i;

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] to_cnt_q, to_cnt_d;

  assign to_hit = (state_q != IDLE) && (to_cnt_q == CW'(TIMEOUT_CYC));

  // Watchdog count: cleared on grant, advancing while a conversion is outstanding
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (grant_fire)
      to_cnt_d = '0;
    else if (state_q != IDLE && !to_hit)
      to_cnt_d = to_cnt_q + 1'b1;
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: LAUNCH waits for the converter to take the start,
  // RUN waits for busy to fall (or the watchdog to expire)
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_fire) state_d = LAUNCH;
      LAUNCH: begin
        if (to_hit)           state_d = IDLE;
        else if (conv_busy_i) state_d = RUN;
      end
      RUN:     if (!conv_busy_i || to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: start strobe from state, ready from the combinational grant
  always_comb begin
    conv_start_o = (state_q == LAUNCH);
    req_ready_o  = grant_fire ? onehot(grant_idx) : '0;
  end

  // Next values for operand, owner and the one-cycle response
  always_comb begin
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    bin_d       = bin_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_bcd_d   = rsp_bcd_q;
    if (grant_fire) begin
      ptr_d = grant_idx;
      gnt_d = grant_idx;
      bin_d = bin_sel;
    end
    if (conv_done) begin
      rsp_valid_d = onehot(gnt_q);
      rsp_bcd_d   = conv_bcd_i;
    end else if (to_hit) begin
      rsp_valid_d = onehot(gnt_q);
      rsp_err_d   = 1'b1;
      rsp_bcd_d   = '0;
    end
  end

  // Operand, owner and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= PW'(NREQ - 1);
      gnt_q       <= '0;
      bin_q       <= '0;
      rsp_valid_q <= '0;
      rsp_bcd_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      bin_q       <= bin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bcd_q   <= rsp_bcd_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign conv_bin_o  = bin_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_bcd_o   = rsp_bcd_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter with a cycle-accurate converter model.
// Build with BCD_ARB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_bcd_conv_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 50;
  localparam int LAT  = 45;
  localparam int QD   = 32;

  typedef struct {
    int          req;
    logic [23:0] bcd;
    bit          err;
    int          cyc;
    int          lat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*20-1:0] req_bin = '0;
  logic [NREQ-1:0]    rsp_valid;
  logic [23:0]        rsp_bcd;
  logic               rsp_err;
  logic               conv_start;
  logic [19:0]        conv_bin;
  logic               conv_busy;
  logic [23:0]        conv_bcd;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_grant  = 0;
  bit   inflight = 1'b0;
  bit   stuck    = 1'b0;
  bit   force_busy = 1'b0;
  int   opq  [NREQ][QD];
  int   head [NREQ] = '{default: 0};
  int   tail [NREQ] = '{default: 0};

  bcd_conv_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_bin_i    (req_bin),
    .rsp_valid_o  (rsp_valid),
    .rsp_bcd_o    (rsp_bcd),
    .rsp_err_o    (rsp_err),
    .conv_start_o (conv_start),
    .conv_bin_o   (conv_bin),
    .conv_busy_i  (conv_busy),
    .conv_bcd_i   (conv_bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r = '0;
    int x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Converter model: start sampled while idle, busy for 42 cycles
  // (start + 39 shift/add + finish + idle), result held after busy falls.
  logic        m_busy = 1'b0;
  int          m_cnt  = 0;
  logic [19:0] m_bin  = '0;
  logic [23:0] m_bcd  = '0;
  assign conv_busy = m_busy | force_busy;
  assign conv_bcd  = m_bcd;
  always @(posedge clk) begin
    if (!m_busy) begin
      if (conv_start && !force_busy) begin
        m_busy <= 1'b1;
        m_cnt  <= 41;
        m_bin  <= conv_bin;
      end
    end else if (!stuck) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0;
        m_bcd  <= to_bcd(int'(m_bin));
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push(input int r, input int v);
    int n = 0;
    while (tail[r] - head[r] >= QD && n < 5000) begin
      @(posedge clk);
      n++;
    end
    opq[r][tail[r] % QD] = v;
    tail[r]++;
  endtask

  function automatic bit pending_empty();
    for (int k = 0; k < NREQ; k++)
      if (head[k] != tail[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_quiet(input int budget);
    int n = 0;
    while (n < budget && !(req_valid == '0 && !inflight && sb.size() == 0 &&
                           !conv_busy && pending_empty())) begin
      @(posedge clk);
      n++;
    end
    chk("quiet_within_budget", 32'(n < budget), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    chk({tag, "_rsp_bcd"},    32'(rsp_bcd),    32'd0);
    chk({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
    chk({tag, "_conv_start"}, 32'(conv_start), 32'd0);
    chk({tag, "_conv_bin"},   32'(conv_bin),   32'd0);
  endtask

  function automatic int rand_operand();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 999999;
      default: return int'($urandom_range(0, 999999));
    endcase
  endfunction

  // Requester driver: holds valid and operand until accepted, then moves on
  initial begin
    logic [NREQ-1:0] acc;
    forever begin
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (acc[k]) begin
          req_valid[k] = 1'b0;
          head[k]++;
        end
        if (!req_valid[k] && head[k] != tail[k]) begin
          req_valid[k] = 1'b1;
          req_bin[k*20 +: 20] = 20'(opq[k][head[k] % QD]);
        end
      end
    end
  end

  // Grant reference: a free arbiter with an idle converter serves the first
  // valid requester after the previous winner; accepted work is queued.
  initial begin
    int last;
    int g;
    int c;
    logic [NREQ-1:0] want;
    exp_t e;
    last = NREQ - 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        inflight = 1'b0;
        last     = NREQ - 1;
        sb.delete();
      end else begin
        if (rsp_valid != '0) inflight = 1'b0;
        g = -1;
        if (!inflight && !conv_busy) begin
          for (int k = 1; k <= NREQ; k++) begin
            c = (last + k) % NREQ;
            if (g < 0 && req_valid[c]) g = c;
          end
        end
        want = '0;
        if (g >= 0) want[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(want));
        chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (g >= 0) begin
          e.req = g;
          e.err = stuck;
          e.bcd = stuck ? 24'h0 : to_bcd(int'(req_bin[g*20 +: 20]));
          e.cyc = cyc;
          e.lat = stuck ? TO + 2 : LAT;
          sb.push_back(e);
          last     = g;
          inflight = 1'b1;
          n_grant++;
        end
      end
    end
  end

  // Response monitor: every result pulse must match the oldest accepted request
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_valid",   32'(rsp_valid), 32'(1 << e.req));
          chk("rsp_bcd",     32'(rsp_bcd),   32'(e.bcd));
          chk("rsp_err",     32'(rsp_err),   32'(e.err));
          chk("rsp_latency", 32'(cyc - e.cyc), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL global_time_limit got=%0d want=done", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int g0;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;

    // Contention from reset: 0,1,2,3 in order
    push(0, 0);
    push(1, 9);
    push(2, 999999);
    push(3, 10);
    wait_quiet(400);

    // Single request
    push(0, 'h12345);
    wait_quiet(200);

    // Fairness between requesters 1 and 3
    for (int i = 0; i < 4; i++) begin
      push(1, rand_operand());
      push(3, rand_operand());
    end
    wait_quiet(600);

    // Busy hold-off in IDLE
    force_busy = 1'b1;
    push(2, rand_operand());
    repeat (12) @(posedge clk);
    #1 force_busy = 1'b0;
    wait_quiet(200);

    // Reset in the middle of RUN
    g0 = n_grant;
    push(0, rand_operand());
    n = 0;
    while (n_grant == g0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("midrun_grant_seen", 32'(n < 50), 32'd1);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("post_reset");
    push(1, rand_operand());
    wait_quiet(300);

    // Randomised traffic
    for (int i = 0; i < 24; i++) begin
      push(int'($urandom_range(0, NREQ - 1)), rand_operand());
      repeat ($urandom_range(0, 70)) @(posedge clk);
      #1;
    end
    wait_quiet(3000);

`ifdef BCD_ARB_TIMEOUT_EN
    // Converter never drops busy: watchdog answers with an error
    stuck = 1'b1;
    g0 = n_grant;
    push(1, rand_operand());
    n = 0;
    while (n_grant == g0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("timeout_grant_seen", 32'(n < 50), 32'd1);
    repeat (TO + 10) @(posedge clk);
    #1;
    push(2, rand_operand());
    repeat (20) @(posedge clk);
    #1 stuck = 1'b0;
    wait_quiet(300);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin arbiter and sequencer that shares one serial binary-to-BCD converter (20-bit binary in, 24-bit BCD out, busy/start handshake) among `NREQ` requesters. It takes the accepted operand, launches the converter, tracks the conversion through the converter's busy signal, and returns the result to the originating requester. It sits between the display/reporting clients and the single converter instance.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT_CYC`, 255: watchdog limit in cycles. Used only with `BCD_ARB_TIMEOUT_EN`.

- `clk`  in  1  clock; everything is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid_i`  in  NREQ  per-requester operand valid.
- `req_ready_o`  out  NREQ  per-requester accept, one-hot or zero.
- `req_bin_i`  in  NREQ*20  operands; requester k uses bits [20k+19:20k].
- `rsp_valid_o`  out  NREQ  one-cycle one-hot result pulse to the owning requester.
- `rsp_bcd_o`  out  24  result; valid while `rsp_valid_o` is nonzero.
- `rsp_err_o`  out  1  timeout flag; qualified by `rsp_valid_o`.
- `conv_start_o`  out  1  converter start request.
- `conv_bin_o`  out  20  converter operand.
- `conv_busy_i`  in  1  converter busy; low only when the converter is ready to accept a start.
- `conv_bcd_i`  in  24  converter result; holds its value once busy falls.

## Operation
- FSM states: IDLE, LAUNCH, RUN.
- **IDLE**
  - `conv_start_o`=0.
  - If any `req_valid_i` is high and `conv_busy_i`=0, pick grant g by round robin: search from `ptr+1` upward, with wrap-around.
  - Drive `req_ready_o[g]`=1 combinationally in that cycle.
  - On the clock edge: `bin_q`<=operand g, `gnt_q`<=g, `ptr`<=g, go to LAUNCH.
  - If `conv_busy_i`=1, grant nothing.
- **LAUNCH**
  - `conv_start_o`=1.
  - Stay in LAUNCH until `conv_busy_i`=1 is sampled, then go to RUN.
- **RUN**
  - `conv_start_o`=0.
  - When `conv_busy_i`=0 is sampled: on the next edge set `rsp_bcd_o`<=`conv_bcd_i` and `rsp_valid_o`<=onehot(`gnt_q`) for one cycle, and go to IDLE.
- `conv_bin_o`=`bin_q` at all times. It changes only on a grant, so it is stable through the converter's operand-capture cycle.
- A requester holds `req_valid_i` and its operand until it sees `req_ready_o`. Dropping valid before acceptance is permitted and simply forfeits the turn.
- `rsp_valid_o` and a new grant may occur in the same cycle, including for the same requester.
- Reset values:
  - state=IDLE, `ptr`=NREQ-1 (so requester 0 wins first), `bin_q`=0, `gnt_q`=0.
  - All outputs 0: `req_ready_o`, `rsp_valid_o`, `rsp_bcd_o`, `rsp_err_o`, `conv_start_o`, `conv_bin_o`.
- Reset mid-conversion:
  - The in-flight result is discarded and no `rsp_valid_o` is issued.
  - If the converter is still busy, IDLE holds off granting until `conv_busy_i`=0.

## Timing
- Accept cycle c0 (`req_ready_o[g]`=1).
- c1: LAUNCH with `conv_start_o`=1; the converter samples start.
- c2: `conv_busy_i`=1 seen; transition to RUN.
- With the 20-bit converter (1 start + 39 loop + finish + idle cycles), busy falls in c44.
- `rsp_valid_o` is high in c45: 45 cycles from accept to response.
- Next grant is possible in c45, giving a throughput of one conversion per 45 cycles.
- Grant decision is combinational from `req_valid_i`, `conv_busy_i`, state and `ptr`. All other outputs are registered.

## Configuration
- `BCD_ARB_TIMEOUT_EN` defined:
  - A cycle counter clears on grant and increments in LAUNCH and RUN.
  - On reaching `TIMEOUT_CYC`, the next cycle asserts `rsp_valid_o[gnt_q]` with `rsp_err_o`=1 and `rsp_bcd_o`=0, and the FSM returns to IDLE.
  - IDLE still refuses to grant while `conv_busy_i`=1.
- `BCD_ARB_TIMEOUT_EN` undefined:
  - No counter; LAUNCH and RUN wait indefinitely.
  - `rsp_err_o` tied to 0.

## Test plan
- Single request: requester 0 sends 0x12345 -> `rsp_valid_o`=4'b0001 exactly 45 cycles after accept, `rsp_bcd_o`=0x074565, `rsp_err_o`=0.
- Contention: all four requesters valid from reset, operands 0, 9, 999999 (0xF423F), 10 -> grants in order 0,1,2,3, each spaced 45 cycles apart; results 0x000000, 0x000009, 0x999999, 0x000010, each to its own requester.
- Round-robin fairness: requesters 1 and 3 held valid continuously -> grants alternate 1,3,1,3; `req_ready_o` is never multi-hot.
- Busy hold-off: `conv_busy_i` forced high while in IDLE with requester 2 valid -> no `req_ready_o` until busy is released, then grant 2 the next cycle.
- Reset mid-RUN: `rst` asserted for one cycle at c20 of a conversion -> no `rsp_valid_o`; all outputs 0 the cycle after reset; a new request completes normally.
- Timeout (built with `BCD_ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=50): converter model never drops busy -> `rsp_valid_o[g]`=1 with `rsp_err_o`=1 and `rsp_bcd_o`=0; no further grant until busy drops.
